// File: rtl/rt_ibex_pcs_ctx_ctrl.sv
// rtl/rt_ibex_pcs_ctx_ctrl.sv - nested-interrupt context save/restore controller
// Optional feature: define RT_IBEX_PCS_OVF_TRAP_EN to refuse pushes on a full
// stack and raise a sticky overflow_o; otherwise full pushes overwrite the oldest context.
module rt_ibex_pcs_ctx_ctrl #(
    parameter int NrSavedRegs = 9,
    parameter int DataWidth   = 32,
    parameter int MaxDepth    = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 irq_ack_i,
    input  logic                                 mret_i,
    output logic                                 push_o,
    output logic                                 pop_o,
    input  logic                                 restore_valid_i,
    input  logic [NrSavedRegs*DataWidth-1:0]     restore_data_i,
    output logic                                 rf_we_o,
    output logic [$clog2(NrSavedRegs)-1:0]       rf_widx_o,
    output logic [DataWidth-1:0]                 rf_wdata_o,
    output logic                                 stall_o,
    output logic                                 ack_ready_o,
    output logic [$clog2(MaxDepth+1)-1:0]        depth_o,
    output logic                                 full_o,
    output logic                                 empty_o,
    output logic                                 underflow_o,
    output logic                                 overflow_o
);

    localparam int IdxW   = $clog2(NrSavedRegs);
    localparam int DepthW = $clog2(MaxDepth + 1);
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(NrSavedRegs - 1);
    localparam logic [DepthW-1:0] MaxD    = DepthW'(MaxDepth);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PUSH      = 2'd1,
        POP_WAIT  = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    state_t                           state;
    state_t                           state_next;
    logic [IdxW-1:0]                  index;
    logic [NrSavedRegs*DataWidth-1:0] buffer;
    logic [DepthW-1:0]                depth;

`ifdef RT_IBEX_PCS_OVF_TRAP_EN
    logic ovf_hit;
    logic ovf_flag;
`endif

    assign depth_o     = depth;
    assign full_o      = (depth == MaxD);
    assign empty_o     = (depth == '0);
    assign ack_ready_o = (state == IDLE);

    // State register; reset abandons any save or restore in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and strobe decode; a save request beats a simultaneous mret.
    always_comb begin
        state_next  = state;
        push_o      = 1'b0;
        pop_o       = 1'b0;
        stall_o     = 1'b0;
        rf_we_o     = 1'b0;
        rf_widx_o   = '0;
        rf_wdata_o  = '0;
        underflow_o = 1'b0;
`ifdef RT_IBEX_PCS_OVF_TRAP_EN
        ovf_hit     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (irq_ack_i) begin
`ifdef RT_IBEX_PCS_OVF_TRAP_EN
                    if (full_o) begin
                        ovf_hit = 1'b1;
                    end else begin
                        state_next = PUSH;
                    end
`else
                    state_next = PUSH;
`endif
                end else if (mret_i) begin
                    if (!empty_o) begin
                        pop_o      = 1'b1;
                        stall_o    = 1'b1;
                        state_next = POP_WAIT;
                    end else begin
                        underflow_o = 1'b1;
                    end
                end
            end
            PUSH: begin
                push_o     = 1'b1;
                state_next = IDLE;
            end
            POP_WAIT: begin
                stall_o = 1'b1;
                if (restore_valid_i) begin
                    state_next = WRITEBACK;
                end
            end
            WRITEBACK: begin
                stall_o    = 1'b1;
                rf_we_o    = 1'b1;
                rf_widx_o  = index;
                rf_wdata_o = buffer[int'(index)*DataWidth +: DataWidth];
                if (index == LastIdx) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Nesting depth: count up after each push (saturating), down on each pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            depth <= '0;
        end else if (state == PUSH) begin
            if (depth != MaxD) begin
                depth <= depth + DepthW'(1);
            end
        end else if (pop_o) begin
            depth <= depth - DepthW'(1);
        end
    end

    // Capture the popped context, then walk the write index across it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buffer <= '0;
            index  <= '0;
        end else if (state == POP_WAIT && restore_valid_i) begin
            buffer <= restore_data_i;
            index  <= '0;
        end else if (state == WRITEBACK) begin
            index <= (index == LastIdx) ? '0 : index + IdxW'(1);
        end
    end

`ifdef RT_IBEX_PCS_OVF_TRAP_EN
    // Sticky overflow: set by a refused save on a full stack, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_flag <= 1'b0;
        end else if (ovf_hit) begin
            ovf_flag <= 1'b1;
        end
    end
    assign overflow_o = ovf_flag;
`else
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_rt_ibex_pcs_ctx_ctrl.sv
// tb/tb_rt_ibex_pcs_ctx_ctrl.sv - self-checking bench for rt_ibex_pcs_ctx_ctrl
module tb_rt_ibex_pcs_ctx_ctrl;
    localparam int NR = 9;
    localparam int DW = 32;
    localparam int MD = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          irq = 1'b0;
    logic          mret = 1'b0;
    logic          valid = 1'b0;
    logic [NR*DW-1:0] rdata = '0;
    logic          push, pop, we, stall, ack, full, empty, uf, ovf;
    logic [3:0]    widx;
    logic [DW-1:0] wdata;
    logic [3:0]    depth;

    int tests = 0;
    int fails = 0;

`ifdef RT_IBEX_PCS_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    rt_ibex_pcs_ctx_ctrl #(.NrSavedRegs(NR), .DataWidth(DW), .MaxDepth(MD)) dut (
        .clk_i(clk), .rst_ni(rst_n), .irq_ack_i(irq), .mret_i(mret),
        .push_o(push), .pop_o(pop), .restore_valid_i(valid), .restore_data_i(rdata),
        .rf_we_o(we), .rf_widx_o(widx), .rf_wdata_o(wdata), .stall_o(stall),
        .ack_ready_o(ack), .depth_o(depth), .full_o(full), .empty_o(empty),
        .underflow_o(uf), .overflow_o(ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required end before)", $time);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; irq = 1'b0; mret = 1'b0; valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_push();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        tick();
    endtask

    typedef struct {
        logic irq;
        logic mret;
        logic push;
        logic pop;
        logic stall;
        logic uf;
        logic ack;
        int   depth;
    } vec_t;

    vec_t tbl[12];

    // Reference model state: transaction view of the controller.
    int           m_depth;
    bit           m_push_pend;
    bit           m_waiting;
    bit           m_ovf;
    logic [31:0]  m_q[$];

    initial begin
        int nw;
        int low;
        int cnt;
        bit found;
        bit any_we;

        tbl[0]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 1, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0, 1, 0};
        tbl[4]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{1, 1, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{0, 1, 1, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 1, 2};
        tbl[9]  = '{1, 1, 0, 0, 0, 0, 1, 2};
        tbl[10] = '{0, 0, 1, 0, 0, 0, 0, 2};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 1, 3};

        // Reset state, observed while reset is held.
        rst_n = 1'b0;
        #3;
        chk("reset_flags", {ack, empty, full, stall, we, push, pop, uf, ovf}, 9'b110000000);
        chk("reset_depth", depth, 0);
        do_reset();

        // Table: underflow, push latency, save-beats-mret, mret ignored outside IDLE.
        for (int i = 0; i < 12; i++) begin
            irq = tbl[i].irq;
            mret = tbl[i].mret;
            @(negedge clk);
            chk($sformatf("tbl%0d_flags", i), {push, pop, stall, uf, ack, we},
                {tbl[i].push, tbl[i].pop, tbl[i].stall, tbl[i].uf, tbl[i].ack, 1'b0});
            chk($sformatf("tbl%0d_depth", i), depth, tbl[i].depth);
            tick();
        end
        irq = 1'b0; mret = 1'b0;

        // Restore at depth 1 with restore_valid three cycles after pop.
        do_reset();
        do_push();
        chk("restore_depth1", {depth, empty}, {4'd1, 1'b0});
        for (int i = 0; i < NR; i++) rdata[i*DW +: DW] = 32'h100 + i;
        mret = 1'b1;
        @(negedge clk);
        chk("restore_pop_stall", {pop, stall}, 2'b11);
        tick();
        mret = 1'b0;
        nw = 0;
        low = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            valid = (cyc == 3);
            @(negedge clk);
            if (we) begin
                chk($sformatf("wb_idx%0d", nw), widx, nw);
                chk($sformatf("wb_data%0d", nw), wdata, 32'h100 + nw);
                nw++;
            end
            if (!stall) begin
                low = cyc;
                break;
            end
            tick();
        end
        valid = 1'b0;
        chk("restore_latency", low, 13);
        chk("restore_nwrites", nw, NR);
        chk("restore_depth0", {depth, empty, we}, {4'd0, 1'b1, 1'b0});
        tick();

        // Nine saves into an eight-deep stack.
        do_reset();
        cnt = 0;
        for (int k = 0; k < 9; k++) begin
            irq = 1'b1;
            tick();
            irq = 1'b0;
            @(negedge clk);
            if (push) cnt++;
            tick();
        end
        chk("ovf_push_count", cnt, TRAP ? 8 : 9);
        chk("ovf_depth_full", {depth, full}, {4'd8, 1'b1});
        chk("ovf_flag", ovf, TRAP);

        // Asynchronous reset in the middle of writeback.
        do_reset();
        do_push();
        mret = 1'b1;
        tick();
        mret = 1'b0;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (we && widx == 4'd4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_wb_reached_idx4", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_wb_drop", {we, stall, ack, depth}, {1'b0, 1'b0, 1'b1, 4'd0});
        tick();
        rst_n = 1'b1;
        any_we = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (we || stall) any_we = 1'b1;
            tick();
        end
        chk("rst_wb_no_more_writes", any_we, 1'b0);

        // Randomized run against the transaction model.
        do_reset();
        m_depth = 0; m_push_pend = 0; m_waiting = 0; m_ovf = 0;
        m_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit e_idle, e_push, e_pop, e_uf, e_stall, e_we;
            logic [3:0]  e_widx;
            logic [31:0] e_wdata;
            irq   = (cyc < 1500) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
            mret  = ($urandom_range(0, 2) == 0);
            valid = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NR; i++) rdata[i*DW +: DW] = $urandom;
            @(negedge clk);
            e_idle  = !m_push_pend && !m_waiting && (m_q.size() == 0);
            e_push  = m_push_pend;
            e_pop   = e_idle && mret && !irq && (m_depth > 0);
            e_uf    = e_idle && mret && !irq && (m_depth == 0);
            e_we    = (m_q.size() > 0);
            e_stall = e_pop || m_waiting || e_we;
            e_widx  = e_we ? 4'(NR - m_q.size()) : 4'd0;
            e_wdata = e_we ? m_q[0] : 32'd0;
            chk($sformatf("rnd%0d_flags", cyc), {push, pop, stall, uf, we, ack, full, empty, ovf},
                {e_push, e_pop, e_stall, e_uf, e_we, e_idle, (m_depth == MD), (m_depth == 0), m_ovf});
            chk($sformatf("rnd%0d_depth", cyc), depth, m_depth);
            chk($sformatf("rnd%0d_write", cyc), {widx, wdata}, {e_widx, e_wdata});
            if (m_push_pend) begin
                if (m_depth < MD) m_depth++;
                m_push_pend = 0;
            end else if (m_waiting) begin
                if (valid) begin
                    for (int i = 0; i < NR; i++) m_q.push_back(rdata[i*DW +: DW]);
                    m_waiting = 0;
                end
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_front());
            end else if (irq) begin
                if (TRAP && m_depth == MD) m_ovf = 1;
                else m_push_pend = 1;
            end else if (mret && m_depth > 0) begin
                m_depth--;
                m_waiting = 1;
            end
            tick();
        end
        irq = 1'b0; mret = 1'b0; valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
